// File: rtl/crc32_frame_checker_if.sv
// Byte-stream interface for crc32_frame_checker.
//   s_data  : stream byte
//   s_valid : byte offered by the source
//   s_last  : byte is the final byte of a frame (last FCS byte)
//   s_ready : sink can take the byte; a transfer happens when s_valid && s_ready
// Modports: master = byte source, slave = frame checker.
interface crc32_frame_checker_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker.
// Each frame on the byte stream ends with a 4-byte FCS, least-significant byte
// first. Bytes pass through a 4-byte delay line, so only payload bytes ever
// reach the bit-serial CRC engine (reflected CRC-32, init/xorout all-ones,
// LSB first, one bit per clock). At end of frame the computed CRC is compared
// with the FCS still sitting in the delay line.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   stream      : byte stream (slave modport of crc32_frame_checker_if)
//   m_done      : one-cycle pulse, frame result valid
//   m_crc_ok    : computed CRC equals received FCS (held)
//   m_runt      : frame shorter than 4 bytes (held)
//   m_crc_calc  : computed CRC after xorout (held)
//   m_crc_rx    : received FCS (held)
//   m_len       : bytes in frame including FCS, saturating (held)
//   busy        : frame in progress
module crc32_frame_checker #(
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  crc32_frame_checker_if.slave    stream,
  output logic                    m_done,
  output logic                    m_crc_ok,
  output logic                    m_runt,
  output logic [31:0]             m_crc_calc,
  output logic [31:0]             m_crc_rx,
  output logic [LEN_W-1:0]        m_len,
  output logic                    busy
);

  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, ACCEPT, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       dl_reg [4];
  logic [7:0]       dl_next [4];
  logic [2:0]       fill_reg, fill_next;
  logic [31:0]      crc_reg, crc_next;
  logic [7:0]       sh_reg, sh_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic             last_pend_reg, last_pend_next;
  logic [LEN_W-1:0] len_reg, len_next;

  logic             ok_reg, runt_reg;
  logic [31:0]      calc_reg, rx_reg;
  logic [LEN_W-1:0] mlen_reg;

  logic [31:0]      poly_ref;
  logic [31:0]      rx_pack;
  logic             ready;
  logic             accept;
  logic             frame_end;

  // Reflected processing shifts right, so the polynomial is bit-reversed.
  // The FCS is assembled with the oldest delay-line byte in the low lane.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_poly_ref
      assign poly_ref[gi] = POLY[31-gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_rx_pack
      assign rx_pack[gi*8 +: 8] = dl_next[gi];
    end
  endgenerate

  assign ready          = (state_reg == IDLE) || (state_reg == ACCEPT);
  assign accept         = stream.s_valid && ready;
  assign stream.s_ready = ready;
  assign frame_end      = (state_next == DONE);

  always_comb begin
    state_next     = state_reg;
    fill_next      = fill_reg;
    crc_next       = crc_reg;
    sh_next        = sh_reg;
    bit_cnt_next   = bit_cnt_reg;
    last_pend_next = last_pend_reg;
    len_next       = len_reg;
    for (int i = 0; i < 4; i++) dl_next[i] = dl_reg[i];

    case (state_reg)
      IDLE, ACCEPT: begin
        // Holding init while idle means the engine is primed when a frame starts.
        if (state_reg == IDLE) crc_next = CRC_INIT;
        if (accept) begin
          len_next = (&len_reg) ? len_reg : len_reg + 1'b1;
          if (fill_reg == 3'd4) begin
            // Full delay line: oldest byte moves on to the CRC engine.
            sh_next        = dl_reg[0];
            dl_next[0]     = dl_reg[1];
            dl_next[1]     = dl_reg[2];
            dl_next[2]     = dl_reg[3];
            dl_next[3]     = stream.s_data;
            bit_cnt_next   = 3'd0;
            last_pend_next = stream.s_last;
            state_next     = SHIFT;
          end else begin
            dl_next[fill_reg[1:0]] = stream.s_data;
            fill_next              = fill_reg + 3'd1;
            state_next             = stream.s_last ? DONE : ACCEPT;
          end
        end
      end
      SHIFT: begin
        crc_next     = {1'b0, crc_reg[31:1]} ^ (poly_ref & {32{crc_reg[0] ^ sh_reg[0]}});
        sh_next      = {1'b0, sh_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = last_pend_reg ? DONE : ACCEPT;
      end
      DONE: begin
        state_next     = IDLE;
        fill_next      = 3'd0;
        crc_next       = CRC_INIT;
        len_next       = '0;
        last_pend_next = 1'b0;
        for (int i = 0; i < 4; i++) dl_next[i] = 8'h00;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      fill_reg      <= 3'd0;
      crc_reg       <= 32'h0;
      sh_reg        <= 8'h00;
      bit_cnt_reg   <= 3'd0;
      last_pend_reg <= 1'b0;
      len_reg       <= '0;
      for (int i = 0; i < 4; i++) dl_reg[i] <= 8'h00;
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      crc_reg       <= crc_next;
      sh_reg        <= sh_next;
      bit_cnt_reg   <= bit_cnt_next;
      last_pend_reg <= last_pend_next;
      len_reg       <= len_next;
      for (int i = 0; i < 4; i++) dl_reg[i] <= dl_next[i];
    end
  end

  // Results are captured on the edge that enters DONE, so they are already
  // valid while m_done is high. A runt never filled the delay line; unused
  // lanes are zero, which gives the zero-extended FCS for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_reg   <= 1'b0;
      runt_reg <= 1'b0;
      calc_reg <= 32'h0;
      rx_reg   <= 32'h0;
      mlen_reg <= '0;
    end else if (frame_end) begin
      calc_reg <= crc_next ^ CRC_XOROUT;
      rx_reg   <= rx_pack;
      runt_reg <= (fill_next != 3'd4);
      ok_reg   <= ((crc_next ^ CRC_XOROUT) == rx_pack) && (fill_next == 3'd4);
      mlen_reg <= len_next;
    end
  end

  assign m_done     = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign m_crc_ok   = ok_reg;
  assign m_runt     = runt_reg;
  assign m_crc_calc = calc_reg;
  assign m_crc_rx   = rx_reg;
  assign m_len      = mlen_reg;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Testbench for crc32_frame_checker: directed frames plus randomized frames and
// gaps, checked every cycle against a frame-level reference model.
module tb_crc32_frame_checker;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_done, m_crc_ok, m_runt, busy;
  logic [31:0] m_crc_calc, m_crc_rx;
  logic [15:0] m_len;

  always #5 clk = ~clk;

  crc32_frame_checker_if bus ();

  crc32_frame_checker #(.POLY(32'h04C11DB7), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .stream(bus),
    .m_done(m_done), .m_crc_ok(m_crc_ok), .m_runt(m_runt),
    .m_crc_calc(m_crc_calc), .m_crc_rx(m_crc_rx), .m_len(m_len), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard byte-wise reflected CRC-32 over the first n bytes of q.
  function automatic logic [31:0] crc32_ref(input bq_t q, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;
  bq_t         cur;
  longint      cyc = 0;
  longint      ready_low_until = -1, done_cyc = -1, busy_from = NEVER, busy_until = -1;
  logic        p_ok, p_runt, h_ok, h_runt;
  logic [31:0] p_calc, p_rx, h_calc, h_rx;
  logic [15:0] p_len, h_len;
  int          frames_done = 0;

  initial begin
    h_ok = 0; h_runt = 0; h_calc = 0; h_rx = 0; h_len = 0;
    p_ok = 0; p_runt = 0; p_calc = 0; p_rx = 0; p_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cur.delete();
        ready_low_until = -1; done_cyc = -1; busy_from = NEVER; busy_until = -1;
        h_ok = 0; h_runt = 0; h_calc = 0; h_rx = 0; h_len = 0;
      end else begin
        if (cyc == done_cyc) begin
          h_ok = p_ok; h_runt = p_runt; h_calc = p_calc; h_rx = p_rx; h_len = p_len;
          frames_done++;
          $display("frame %0d: len=%0d runt=%0d ok=%0d calc=%08h rx=%08h",
                   frames_done, m_len, m_runt, m_crc_ok, m_crc_calc, m_crc_rx);
        end
        check("s_ready", 32'(bus.s_ready), 32'(cyc > ready_low_until));
        check("m_done", 32'(m_done), 32'(cyc == done_cyc));
        check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_until));
        check("m_crc_ok", 32'(m_crc_ok), 32'(h_ok));
        check("m_runt", 32'(m_runt), 32'(h_runt));
        check("m_crc_calc", m_crc_calc, h_calc);
        check("m_crc_rx", m_crc_rx, h_rx);
        check("m_len", 32'(m_len), 32'(h_len));

        if (bus.s_valid && bus.s_ready) begin
          int n;
          cur.push_back(bus.s_data);
          n = cur.size();
          if (n == 1) begin busy_from = cyc + 1; busy_until = NEVER; end
          if (n >= 5) ready_low_until = cyc + 8;
          if (bus.s_last) begin
            done_cyc        = (n >= 5) ? cyc + 9 : cyc + 1;
            ready_low_until = done_cyc;
            busy_until      = done_cyc;
            p_len  = 16'(n);
            p_runt = (n < 4);
            p_rx   = 32'h0;
            if (n < 4) for (int i = 0; i < n; i++) p_rx[8*i +: 8] = cur[i];
            else       for (int i = 0; i < 4; i++) p_rx[8*i +: 8] = cur[n-4+i];
            p_calc = crc32_ref(cur, (n < 4) ? 0 : n - 4);
            p_ok   = !p_runt && (p_calc == p_rx);
            cur.delete();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap_max);
    int gap;
    int waits;
    bit acc;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    acc   = 1'b0;
    waits = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #1;
      waits++;
      if (!acc && waits > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap_max);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], i == f.size() - 1, gap_max);
  endtask

  // Leaves the caller at the negedge of the m_done cycle.
  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_done && k < 30);
    if (!m_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  bq_t f1, f2, f3, f4, fr;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    f2 = f1;
    f2[4] = 8'h36;
    f3 = '{8'h00, 8'h00, 8'h00, 8'h00};
    f4 = '{8'hAA, 8'hBB, 8'hCC};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model against the published CRC-32 check value.
    check("model_check_value", crc32_ref(f1, 9), 32'hCBF43926);

    // Standard check frame, no gaps.
    send_frame(f1, 0);
    wait_done();
    check("t1_calc", m_crc_calc, 32'hCBF43926);
    check("t1_rx", m_crc_rx, 32'hCBF43926);
    check("t1_ok", 32'(m_crc_ok), 32'd1);
    check("t1_runt", 32'(m_runt), 32'd0);
    check("t1_len", 32'(m_len), 32'd13);
    resync();

    // Corrupted payload byte.
    send_frame(f2, 0);
    wait_done();
    check("t2_ok", 32'(m_crc_ok), 32'd0);
    check("t2_rx", m_crc_rx, 32'hCBF43926);
    check("t2_calc_differs", 32'(m_crc_calc != 32'hCBF43926), 32'd1);
    check("t2_len", 32'(m_len), 32'd13);
    resync();

    // Exactly four bytes: empty payload.
    send_frame(f3, 0);
    wait_done();
    check("t3_calc", m_crc_calc, 32'h0);
    check("t3_ok", 32'(m_crc_ok), 32'd1);
    check("t3_len", 32'(m_len), 32'd4);
    resync();

    // Runt frame.
    send_frame(f4, 0);
    wait_done();
    check("t4_runt", 32'(m_runt), 32'd1);
    check("t4_ok", 32'(m_crc_ok), 32'd0);
    check("t4_len", 32'(m_len), 32'd3);
    check("t4_rx", m_crc_rx, 32'h00CCBBAA);
    resync();

    // Back-to-back frames with random gaps.
    send_frame(f1, 3);
    send_frame(f3, 3);
    repeat (20) resync();
    check("t5_len", 32'(m_len), 32'd4);
    check("t5_ok", 32'(m_crc_ok), 32'd1);

    // Reset in the middle of the SHIFT of byte 6.
    for (int i = 0; i < 6; i++) send_byte(f1[i], 1'b0, 0);
    repeat (3) resync();
    rst = 1'b1;
    repeat (2) resync();
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(bus.s_ready), 32'd1);
    check("t6_done", 32'(m_done), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ok", 32'(m_crc_ok), 32'd0);
    check("t6_calc", m_crc_calc, 32'h0);
    check("t6_rx", m_crc_rx, 32'h0);
    check("t6_len", 32'(m_len), 32'd0);
    resync();
    send_frame(f1, 0);
    wait_done();
    check("t6_after_ok", 32'(m_crc_ok), 32'd1);
    check("t6_after_len", 32'(m_len), 32'd13);
    resync();

    // Random frames, some with a flipped bit.
    for (int f = 0; f < 14; f++) begin
      int n;
      logic [31:0] c;
      logic [7:0]  flip;
      n = (f == 0) ? 4 : (f == 1) ? 5 : int'($urandom_range(1, 12));
      fr.delete();
      if (n >= 4) begin
        for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
        c = crc32_ref(fr, n - 4);
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
        if ($urandom_range(0, 2) == 0) begin
          flip = 8'h01 << $urandom_range(0, 7);
          fr[$urandom_range(0, n - 1)] ^= flip;
        end
      end else begin
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      send_frame(fr, 2);
      wait_done();
      resync();
    end

    repeat (10) resync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
